serial_compare_ctrl: RTL and testbench

Sequenced magnitude comparator for wide operands. Latches two WIDTH-bit operands and compares them one DIGIT-bit slice per cycle, MSB slice first, using a single shared DIGIT-bit less/equal/greater slice compare. It stops early at the first unequal slice and presents a one-hot less/equal/greater result. It is a small-area alternative to the flat comparators in the combinational library, used where area matters more than latency.

---
 rtl/serial_compare_ctrl.sv | 161 ++++++++++++++++
 tb/tb_serial_compare_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: sequenced unsigned magnitude comparator for wide operands.
// Latches A and B on accept, then compares one DIGIT-bit slice per cycle,
// most-significant slice first, through a single shared slice comparator.
// It stops at the first unequal slice and reports a one-hot less/equal/greater
// result together with the number of slice compares performed.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start_valid  request to start a compare
//   start_ready  high only while idle; accept = start_valid & start_ready
//   a, b         WIDTH-bit operands, sampled on accept only
//   abort        cancels a compare in progress (no result, no done)
//   busy         high while slices are being compared
//   done         one-cycle pulse when the result becomes valid
//   less/equal/greater  one-hot result, held until the next accept
//   cycles       slice compares used for the last result (1..NDIG)
module serial_compare_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 2,
    localparam int unsigned NDIG = WIDTH / DIGIT,
    localparam int unsigned CW   = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic [CW-1:0]    cycles
);

    // Slice index width; a single-slice configuration still needs one bit.
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               start_ready_d;
    logic               busy_d;
    logic               done_d;
    logic               less_d;
    logic               equal_d;
    logic               greater_d;
    logic [CW-1:0]      cycles_d;

    logic [DIGIT-1:0]   slice_a_c;
    logic [DIGIT-1:0]   slice_b_c;

    // Shared slice selector: slice idx of the latched operands.
    always_comb begin
        slice_a_c = DIGIT'(a_q >> (idx_q * DIGIT));
        slice_b_c = DIGIT'(b_q >> (idx_q * DIGIT));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        less_d    = less;
        equal_d   = equal;
        greater_d = greater;
        cycles_d  = cycles;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IW'(NDIG - 1);
                    cnt_d     = '0;
                    less_d    = 1'b0;
                    equal_d   = 1'b0;
                    greater_d = 1'b0;
                    cycles_d  = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // Results were cleared at accept, so nothing is published.
                    state_d = IDLE;
                end else if (slice_a_c != slice_b_c) begin
                    less_d    = (slice_a_c < slice_b_c);
                    greater_d = (slice_a_c > slice_b_c);
                    cycles_d  = CW'(cnt_q + CW'(1));
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (idx_q == '0) begin
                    equal_d  = 1'b1;
                    cycles_d = CW'(NDIG);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = IW'(idx_q - IW'(1));
                    cnt_d = CW'(cnt_q + CW'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d == RUN);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            less        <= 1'b0;
            equal       <= 1'b0;
            greater     <= 1'b0;
            cycles      <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            start_ready <= start_ready_d;
            busy        <= busy_d;
            done        <= done_d;
            less        <= less_d;
            equal       <= equal_d;
            greater     <= greater_d;
            cycles      <= cycles_d;
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Testbench for serial_compare_ctrl: four instances (DIGIT = 1, 2, 4, 16,
// WIDTH = 16) share stimulus. Directed tables and sequences target the
// DIGIT=2 instance; random operand pairs are checked on all four against a
// reference built from plain unsigned compares and the top differing bit.
module tb_serial_compare_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        abort;

    logic       d1_rdy, d1_busy, d1_done, d1_less, d1_equal, d1_greater;
    logic [4:0] d1_cycles;
    logic       d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater;
    logic [3:0] d2_cycles;
    logic       d4_rdy, d4_busy, d4_done, d4_less, d4_equal, d4_greater;
    logic [2:0] d4_cycles;
    logic       d16_rdy, d16_busy, d16_done, d16_less, d16_equal, d16_greater;
    logic       d16_cycles;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(d1_rdy),
        .a(a), .b(b), .abort(abort), .busy(d1_busy), .done(d1_done),
        .less(d1_less), .equal(d1_equal), .greater(d1_greater), .cycles(d1_cycles));
    serial_compare_ctrl #(.WIDTH(16), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(d2_rdy),
        .a(a), .b(b), .abort(abort), .busy(d2_busy), .done(d2_done),
        .less(d2_less), .equal(d2_equal), .greater(d2_greater), .cycles(d2_cycles));
    serial_compare_ctrl #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(d4_rdy),
        .a(a), .b(b), .abort(abort), .busy(d4_busy), .done(d4_done),
        .less(d4_less), .equal(d4_equal), .greater(d4_greater), .cycles(d4_cycles));
    serial_compare_ctrl #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(d16_rdy),
        .a(a), .b(b), .abort(abort), .busy(d16_busy), .done(d16_done),
        .less(d16_less), .equal(d16_equal), .greater(d16_greater), .cycles(d16_cycles));

    // Per-instance views, index 0..3 = DIGIT 1, 2, 4, 16.
    logic [3:0] rdy_v, busy_v, done_v, less_v, equal_v, greater_v;
    logic [4:0] cyc_v [4];
    assign rdy_v     = {d16_rdy, d4_rdy, d2_rdy, d1_rdy};
    assign busy_v    = {d16_busy, d4_busy, d2_busy, d1_busy};
    assign done_v    = {d16_done, d4_done, d2_done, d1_done};
    assign less_v    = {d16_less, d4_less, d2_less, d1_less};
    assign equal_v   = {d16_equal, d4_equal, d2_equal, d1_equal};
    assign greater_v = {d16_greater, d4_greater, d2_greater, d1_greater};
    assign cyc_v[0]  = 5'(d1_cycles);
    assign cyc_v[1]  = 5'(d2_cycles);
    assign cyc_v[2]  = 5'(d4_cycles);
    assign cyc_v[3]  = 5'(d16_cycles);

    int unsigned dig [4] = '{1, 2, 4, 16};

    int n_cmp = 0;
    int n_bad = 0;

    // Results captured by do_cmp.
    logic [3:0] seen_r;
    logic [2:0] leg_r [4];
    int         cyc_r [4];
    int         lat_r [4];
    int         bcnt_r [4];
    bit         inv_ok;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [2:0]  leg;   // {less, equal, greater}
        int          cyc;
    } vec_t;

    function automatic void chk(input bit ok, input string nm, input string info);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", nm, info);
        end
    endfunction

    // Reference: unsigned relation plus position of the top differing bit.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  input int unsigned d, output logic [2:0] leg,
                                  output int cyc);
        logic [15:0] diff;
        int          top;
        diff = x ^ y;
        top  = -1;
        for (int i = 0; i < 16; i++) if (diff[i]) top = i;
        leg = {x < y, x == y, x > y};
        if (top < 0) cyc = 16 / int'(d);
        else         cyc = (15 - top) / int'(d) + 1;
    endfunction

    // One compare on all instances; records latency, busy length and result.
    task automatic do_cmp(input logic [15:0] av, input logic [15:0] bv);
        logic [3:0] seen;
        seen   = '0;
        inv_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lat_r[i] = 0; bcnt_r[i] = 0; cyc_r[i] = 0; leg_r[i] = '0;
        end
        @(negedge clk);
        start_valid = 1'b1; a = av; b = bv;
        @(negedge clk);
        start_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (!seen[i]) begin
                    if (busy_v[i]) bcnt_r[i]++;
                    if (done_v[i]) begin
                        seen[i]  = 1'b1;
                        lat_r[i] = k;
                        leg_r[i] = {less_v[i], equal_v[i], greater_v[i]};
                        cyc_r[i] = int'(cyc_v[i]);
                    end
                end
                if (busy_v[i] && rdy_v[i]) inv_ok = 1'b0;
                if (done_v[i] && !$onehot({less_v[i], equal_v[i], greater_v[i]})) inv_ok = 1'b0;
                if (busy_v[i] && (less_v[i] || equal_v[i] || greater_v[i])) inv_ok = 1'b0;
            end
            if (seen == 4'hF) break;
            @(negedge clk);
        end
        seen_r = seen;
    endtask

    task automatic check_all(input logic [15:0] av, input logic [15:0] bv);
        logic [2:0] el;
        int         ec;
        for (int i = 0; i < 4; i++) begin
            model(av, bv, dig[i], el, ec);
            chk(seen_r[i] && leg_r[i] == el && cyc_r[i] == ec &&
                lat_r[i] == ec + 1 && bcnt_r[i] == ec,
                $sformatf("cmp_digit%0d", dig[i]),
                $sformatf("a=%h b=%h got done=%b leg=%b cyc=%0d lat=%0d busy=%0d need leg=%b cyc=%0d lat=%0d busy=%0d",
                          av, bv, seen_r[i], leg_r[i], cyc_r[i], lat_r[i], bcnt_r[i],
                          el, ec, ec + 1, ec));
        end
        chk(inv_ok, "invariants", $sformatf("a=%h b=%h got ok=%b need 1", av, bv, inv_ok));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running need finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [9];
        int          k;
        bit          saw;
        logic [15:0] ra, rb;

        tbl[0] = '{16'h8000, 16'h7FFF, 3'b001, 1};
        tbl[1] = '{16'hA5A5, 16'hA5A5, 3'b010, 8};
        tbl[2] = '{16'h1234, 16'h1235, 3'b100, 8};
        tbl[3] = '{16'h0100, 16'h0000, 3'b001, 4};
        tbl[4] = '{16'h0000, 16'hFFFF, 3'b100, 1};
        tbl[5] = '{16'h0001, 16'h0000, 3'b001, 8};
        tbl[6] = '{16'h4000, 16'h8000, 3'b100, 1};
        tbl[7] = '{16'h0000, 16'h0004, 3'b100, 7};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 3'b010, 8};

        rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater, d2_cycles} == {6'b100000, 4'd0},
            "reset_state", $sformatf("got rdy=%b busy=%b done=%b leg=%b%b%b cyc=%0d need rdy=1 rest 0",
                                     d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater, d2_cycles));

        // Directed table on DIGIT=2; every instance also checked against the model.
        for (int i = 0; i < 9; i++) begin
            do_cmp(tbl[i].va, tbl[i].vb);
            check_all(tbl[i].va, tbl[i].vb);
            chk(leg_r[1] == tbl[i].leg && cyc_r[1] == tbl[i].cyc && lat_r[1] == tbl[i].cyc + 1 &&
                bcnt_r[1] == tbl[i].cyc,
                $sformatf("table%0d", i),
                $sformatf("got leg=%b cyc=%0d lat=%0d busy=%0d need leg=%b cyc=%0d lat=%0d busy=%0d",
                          leg_r[1], cyc_r[1], lat_r[1], bcnt_r[1], tbl[i].leg, tbl[i].cyc,
                          tbl[i].cyc + 1, tbl[i].cyc));
        end

        // Result held through idle cycles; abort while idle has no effect.
        abort = 1'b1;
        repeat (4) @(negedge clk);
        abort = 1'b0;
        chk({d2_less, d2_equal, d2_greater} == 3'b010 && d2_cycles == 4'd8 && d2_rdy && !d2_done,
            "held_result", $sformatf("got leg=%b%b%b cyc=%0d rdy=%b done=%b need leg=010 cyc=8 rdy=1 done=0",
                                     d2_less, d2_equal, d2_greater, d2_cycles, d2_rdy, d2_done));

        // Abort in the third RUN cycle with equal operands.
        @(negedge clk); start_valid = 1'b1; a = 16'h5A5A; b = 16'h5A5A;
        @(negedge clk); start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk({d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater, d2_cycles} == {6'b100000, 4'd0},
            "abort_idle", $sformatf("got rdy=%b busy=%b done=%b leg=%b%b%b cyc=%0d need rdy=1 rest 0",
                                    d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater, d2_cycles));
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (d2_done || d2_less || d2_equal || d2_greater) saw = 1'b1;
        end
        chk(!saw, "abort_no_done", $sformatf("got done_or_result_seen=%b need 0", saw));

        // Request held across RUN/DONE with operands changing.
        @(negedge clk); start_valid = 1'b1; a = 16'h0100; b = 16'h0000;
        @(negedge clk); a = 16'h0000; b = 16'hFFFF;
        k = 1;
        while (!d2_done && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk(d2_done && k == 5 && {d2_less, d2_equal, d2_greater} == 3'b001 && d2_cycles == 4'd4,
            "held_req_first", $sformatf("got done=%b lat=%0d leg=%b%b%b cyc=%0d need done=1 lat=5 leg=001 cyc=4",
                                        d2_done, k, d2_less, d2_equal, d2_greater, d2_cycles));
        @(negedge clk);
        chk(d2_rdy && !d2_busy, "held_req_idle",
            $sformatf("got rdy=%b busy=%b need rdy=1 busy=0", d2_rdy, d2_busy));
        @(negedge clk);
        start_valid = 1'b0; a = 16'hFFFF; b = 16'h0000;
        chk(d2_busy && {d2_less, d2_equal, d2_greater} == 3'b000 && d2_cycles == 4'd0,
            "held_req_accept", $sformatf("got busy=%b leg=%b%b%b cyc=%0d need busy=1 leg=000 cyc=0",
                                         d2_busy, d2_less, d2_equal, d2_greater, d2_cycles));
        @(negedge clk);
        chk(d2_done && {d2_less, d2_equal, d2_greater} == 3'b100 && d2_cycles == 4'd1,
            "held_req_second", $sformatf("got done=%b leg=%b%b%b cyc=%0d need done=1 leg=100 cyc=1",
                                         d2_done, d2_less, d2_equal, d2_greater, d2_cycles));

        // Reset in the fourth RUN cycle.
        repeat (20) @(negedge clk);
        @(negedge clk); start_valid = 1'b1; a = 16'hA5A5; b = 16'hA5A5;
        @(negedge clk); start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk({d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater, d2_cycles} == {6'b100000, 4'd0},
            "reset_mid_run", $sformatf("got rdy=%b busy=%b done=%b leg=%b%b%b cyc=%0d need rdy=1 rest 0",
                                       d2_rdy, d2_busy, d2_done, d2_less, d2_equal, d2_greater, d2_cycles));
        do_cmp(16'h1234, 16'h1235);
        check_all(16'h1234, 16'h1235);

        // Random regression on all DIGIT values.
        for (int n = 0; n < 10000; n++) begin
            int sel;
            ra  = 16'($urandom);
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      rb = ra;
            else if (sel < 5)  rb = ra ^ (16'd1 << $urandom_range(0, 15));
            else               rb = 16'($urandom);
            do_cmp(ra, rb);
            check_all(ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
